// File: rtl/alu_operand_issue.sv
// rtl/alu_operand_issue.sv - register file, busy scoreboard and registered operand issue toward alu_add
module alu_operand_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr_in,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rs1,
  output logic [WIDTH-1:0] rs2,
  output logic [4:0]       rd_addr
);

  logic [WIDTH-1:0] regs [32];
  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic             hazard;
  logic             accept;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;

  // A busy index is not a hazard when its writeback lands this very cycle.
  function automatic logic blocked(input logic [4:0] idx, input logic [31:0] b,
                                   input logic we, input logic [4:0] wa);
    return (idx != 5'd0) && b[idx] && !(we && (wa == idx));
  endfunction

  always_comb begin
    hazard = blocked(rs1_addr, busy, wb_en, wb_addr)
           | blocked(rs2_addr, busy, wb_en, wb_addr)
           | blocked(rd_addr_in, busy, wb_en, wb_addr);
    in_ready = (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (rs1_addr != 5'd0)
      op1 = (wb_en && (wb_addr == rs1_addr)) ? wb_data : regs[rs1_addr];
    if (rs2_addr != 5'd0)
      op2 = (wb_en && (wb_addr == rs2_addr)) ? wb_data : regs[rs2_addr];
  end

  // Set is applied after clear so an issue reusing the retiring index stays busy.
  always_comb begin
    busy_next = busy;
    if (wb_en)
      busy_next[wb_addr] = 1'b0;
    if (accept && (rd_addr_in != 5'd0))
      busy_next[rd_addr_in] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rs1       <= '0;
      rs2       <= '0;
      rd_addr   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rs1       <= op1;
      rs2       <= op2;
      rd_addr   <= rd_addr_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_operand_issue.md
ALU_OPERAND_ISSUE -- requirements
Module: alu_operand_issue

Interface
REQ-001 Parameter WIDTH, default 32, operand/register data width; only 32 SHALL be supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents an operation to issue.
REQ-005 in_ready  output  1  block accepts the operation this cycle.
REQ-006 rs1_addr, rs2_addr  input  5 each  source register indices.
REQ-007 rd_addr_in  input  5  destination register index of the operation.
REQ-008 wb_en  input  1  writeback strobe from the ALU result path.
REQ-009 wb_addr  input  5  writeback register index.
REQ-010 wb_data  input  WIDTH  writeback value (alu_add rd result).
REQ-011 out_valid  output  1  registered operands valid toward alu_add.
REQ-012 out_ready  input  1  downstream consumes the operands this cycle.
REQ-013 rs1, rs2  output  WIDTH each  registered operands, driving alu_add rs1/rs2.
REQ-014 rd_addr  output  5  registered destination index travelling with the operands.

Function
REQ-015 Register file SHALL hold 32 entries of WIDTH bits; entry 0 SHALL always read 0.
REQ-016 On rising clk with wb_en=1 and wb_addr!=0, entry wb_addr SHALL be written with wb_data; wb_addr=0 writes ignored.
REQ-017 Scoreboard busy[31:0] SHALL track pending writes; busy[0] SHALL always be 0.
REQ-018 hazard SHALL be 1 when any of rs1_addr, rs2_addr, rd_addr_in (nonzero) has busy=1, unless wb_en=1 and wb_addr equals that index this cycle.
REQ-019 in_ready SHALL equal (!out_valid | out_ready) & !hazard, combinational; accept = in_valid & in_ready.
REQ-020 On accept, rs1/rs2 SHALL capture bypassed operands: wb_data when wb_en=1 and wb_addr==index!=0, else register-file value (0 for index 0).
REQ-021 On accept, rd_addr SHALL capture rd_addr_in, out_valid SHALL be 1 next cycle (latency 1 cycle).
REQ-022 On accept with rd_addr_in!=0, busy[rd_addr_in] SHALL set next cycle.
REQ-023 On wb_en=1, busy[wb_addr] SHALL clear next cycle; simultaneous set and clear of the same index SHALL leave busy=1.
REQ-024 wb_en to a non-busy register SHALL still write the register file; busy unchanged.
REQ-025 With out_valid=1 and out_ready=0, rs1, rs2, rd_addr, out_valid SHALL hold stable.
REQ-026 With out_valid=1, out_ready=1 and no accept, out_valid SHALL go 0 next cycle; with accept, back-to-back issue at one op per cycle.
REQ-027 in_valid=0 SHALL never change outputs except out_valid drain per REQ-026.
REQ-028 Data SHALL pass unmodified; no arithmetic, wrap or sign handling in this block.

Reset
REQ-029 rst=1 SHALL immediately force out_valid=0, rs1=0, rs2=0, rd_addr=0, busy=0, all register-file entries 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard the pending output and all scoreboard state; no writeback during rst SHALL take effect.
REQ-031 First accept SHALL be possible on the first rising clk after rst deasserts.

Verification
REQ-032 Reset, then wb x5=10, x6=21, issue rs1=5 rs2=6 rd=7 with out_ready=1 -> next cycle out_valid=1, rs1=10, rs2=21, rd_addr=7.
REQ-033 Issue rd=7, then rs1=7 rs2=0 with out_ready=1 -> in_ready=0 until wb x7=0xFFFFFFFF; that cycle accepted, rs1=0xFFFFFFFF, rs2=0.
REQ-034 Write x0=0x12345678, issue rs1=0 rs2=0 -> rs1=0, rs2=0; busy unchanged when rd=0.
REQ-035 out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> next op issued the following cycle.
REQ-036 Same-cycle wb x3=0xFFFFFFF6 and issue rs1=3 rd=3 after x3 busy -> accepted, rs1=0xFFFFFFF6, busy[3]=1 afterwards.
REQ-037 Assert rst asynchronously while out_valid=1 and busy[9]=1 -> out_valid=0, busy=0, register file zero before next clk edge.
